answer_checker: RTL
===================

// Module: answer_checker
// PURPOSE
//  Downstream consumer of the arithmetic problem generator. While the alarm is armed it latches one
//  problem (num1/op/num2/answer) from the generator, collects up to 3 decimal keypad digits, and
//  judges ENTER presses against the latched answer. Correct -> disarm pulse; too many wrong -> fetch new problem.
// PARAMETERS
//  MAX_TRIES       3      wrong ENTERs allowed per problem (1..15)
//  TIMEOUT_CYCLES  1000   per-problem time limit in clk cycles (used only with ANSWER_TIMEOUT_EN)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset, asynchronous, active-low
//  arm           in   1   alarm active level; low forces IDLE
//  gen_ready     in   1   generator problem-valid strobe (may pulse repeatedly; generator free-runs)
//  gen_answer    in   8   generator answer
//  gen_num1      in   8   generator operand 1
//  gen_num2      in   8   generator operand 2
//  gen_op        in   3   generator op (0 add,1 sub,2 mul,3 div,4 mod)
//  key_valid     in   1   one-cycle key strobe
//  key_code      in   4   0-9 digit, 0xA CLEAR, 0xB ENTER, others ignored
//  prob_num1     out  8   latched operand 1 for display
//  prob_num2     out  8   latched operand 2
//  prob_op       out  3   latched op
//  entry         out  10  current decimal entry value, 0..999
//  entry_len     out  2   digits entered, 0..3
//  tries_left    out  4   remaining wrong attempts
//  solving       out  1   high in ENTRY/JUDGE
//  solved        out  1   one-cycle pulse on correct answer
//  wrong         out  1   one-cycle pulse on incorrect answer
//  timeout       out  1   one-cycle pulse on time expiry (0 without ANSWER_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; all outputs 0 except tries_left=MAX_TRIES. Reset mid-operation discards problem.
//  FSM: IDLE -> WAIT_PROB when arm=1. WAIT_PROB -> ENTRY on first clock with gen_ready=1; that edge latches
//   gen_* into prob_*/answer reg, clears entry/entry_len, tries_left=MAX_TRIES, timer=0.
//  gen_ready ignored in every state except WAIT_PROB; latched problem never changes during ENTRY/JUDGE.
//  ENTRY, key_valid=1: digit with entry_len<3 -> entry<=entry*10+digit, entry_len+1; 4th digit ignored.
//   CLEAR -> entry=0, entry_len=0. ENTER with entry_len=0 ignored; otherwise -> JUDGE. Keys outside ENTRY dropped.
//  JUDGE (one cycle, no key accepted): compare entry == {2'b00,answer}.
//   Equal -> solved=1 next cycle, state IDLE. Entry of ENTER sampled edge N -> solved high in cycle after edge N+1.
//   Not equal -> wrong=1 next cycle, entry/entry_len cleared, tries_left-1; if result 0 -> WAIT_PROB
//   (new problem, tries_left reloads on latch), else -> ENTRY.
//  arm=0 in any state -> IDLE next edge; pulses suppressed; prob_* hold; entry cleared.
//  arm=0 and ENTER-JUDGE same cycle: arm wins, no solved/wrong pulse.
//  solved/wrong/timeout never asserted simultaneously; each exactly one cycle.
// CONFIGURATION
//  ANSWER_TIMEOUT_EN defined: 16-bit timer counts in ENTRY (holds in JUDGE); when it reaches
//   TIMEOUT_CYCLES-1 in ENTRY -> timeout=1 one cycle, entry cleared, state WAIT_PROB. ENTER on the
//   same cycle loses to timeout. Timer resets on each problem latch only (not per key).
//  Undefined: no timer logic; timeout tied 0; problem persists until solved, exhausted or disarmed.
// STRUCTURE
//  Package disarm_pkg: FSM state encodings (IDLE,WAIT_PROB,ENTRY,JUDGE), key codes (KEY_CLEAR=4'hA,
//   KEY_ENTER=4'hB), op encodings shared with generator, ENTRY_W=10.
//  Sub-module digit_accumulator: entry/entry_len register, digit/clear/saturate-at-3 logic; FSM in top.
// TESTING
//  1 Arm, gen problem 23-17 ans 6; keys 6,ENTER -> solved pulse 2 edges after ENTER, state IDLE, prob_num1=23.
//  2 MAX_TRIES=3, ans 6; enter 7 three times -> wrong x3, tries_left 2,1,then reload 3 on next gen_ready latch.
//  3 Keys 1,2,3,4 -> entry=123 len=3; CLEAR -> entry 0; ENTER with len 0 -> no JUDGE, no pulses.
//  4 While in ENTRY, pulse gen_ready with answer 99, then enter original answer -> solved (latch unchanged).
//  5 Drop arm after keys 4,2 -> IDLE next edge, entry 0, no pulse; assert rst low mid-JUDGE -> all outputs reset immediately.
//  6 ANSWER_TIMEOUT_EN, TIMEOUT_CYCLES=100, no keys -> timeout pulse after 100 ENTRY cycles, WAIT_PROB; undefined -> timeout stays 0.

Source files
------------

// File: rtl/disarm_pkg.sv
// rtl/disarm_pkg.sv - shared FSM states, key codes, op codes and widths for answer_checker
package disarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PROB,
        ST_ENTRY,
        ST_JUDGE
    } state_t;

    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam int ENTRY_W = 10;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/answer_checker_if.sv
// rtl/answer_checker_if.sv - problem generator and keypad inputs of answer_checker
interface answer_checker_if;
    logic       gen_ready;
    logic [7:0] gen_answer;
    logic [7:0] gen_num1;
    logic [7:0] gen_num2;
    logic [2:0] gen_op;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        output gen_ready, gen_answer, gen_num1, gen_num2, gen_op, key_valid, key_code
    );

    modport slave (
        input gen_ready, gen_answer, gen_num1, gen_num2, gen_op, key_valid, key_code
    );
endinterface

// File: rtl/digit_accumulator.sv
// rtl/digit_accumulator.sv - decimal keypad entry register, saturating at three digits
module digit_accumulator
    import disarm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    output logic [ENTRY_W-1:0] entry,
    output logic [1:0]         entry_len
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry     <= '0;
            entry_len <= '0;
        end else if (clear) begin
            entry     <= '0;
            entry_len <= '0;
        end else if (digit_valid && entry_len < 2'd3) begin
            // entry <= 99 while len < 3, so the product never exceeds 999
            entry     <= ENTRY_W'(entry * ENTRY_W'(10)) + ENTRY_W'(digit);
            entry_len <= entry_len + 2'd1;
        end
    end

endmodule

// File: rtl/answer_checker.sv
// rtl/answer_checker.sv - latches a generated problem and judges keypad answers; option ANSWER_TIMEOUT_EN
module answer_checker
    import disarm_pkg::*;
#(
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    answer_checker_if.slave    bus,
    output logic [7:0]         prob_num1,
    output logic [7:0]         prob_num2,
    output logic [2:0]         prob_op,
    output logic [ENTRY_W-1:0] entry,
    output logic [1:0]         entry_len,
    output logic [3:0]         tries_left,
    output logic               solving,
    output logic               solved,
    output logic               wrong,
    output logic               timeout
);

    state_t     state_q, state_d;
    logic [7:0] answer_q;
    logic       do_latch, do_solve, do_wrong, do_timeout;
    logic       acc_clear, acc_digit, timer_hit, judge_equal;

    assign judge_equal = (entry == {2'b00, answer_q});
    assign solving     = (state_q == ST_ENTRY) || (state_q == ST_JUDGE);

    always_comb begin
        state_d    = state_q;
        do_latch   = 1'b0;
        do_solve   = 1'b0;
        do_wrong   = 1'b0;
        do_timeout = 1'b0;
        acc_clear  = 1'b0;
        acc_digit  = 1'b0;
        if (!arm) begin
            state_d   = ST_IDLE;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_PROB;
                ST_WAIT_PROB: begin
                    if (bus.gen_ready) begin
                        do_latch  = 1'b1;
                        acc_clear = 1'b1;
                        state_d   = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (timer_hit) begin
                        do_timeout = 1'b1;
                        acc_clear  = 1'b1;
                        state_d    = ST_WAIT_PROB;
                    end else if (bus.key_valid) begin
                        if (is_digit(bus.key_code)) begin
                            acc_digit = 1'b1;
                        end else if (bus.key_code == KEY_CLEAR) begin
                            acc_clear = 1'b1;
                        end else if (bus.key_code == KEY_ENTER && entry_len != 2'd0) begin
                            state_d = ST_JUDGE;
                        end
                    end
                end
                ST_JUDGE: begin
                    acc_clear = 1'b1;
                    if (judge_equal) begin
                        do_solve = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        do_wrong = 1'b1;
                        state_d  = (tries_left <= 4'd1) ? ST_WAIT_PROB : ST_ENTRY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            prob_num1  <= '0;
            prob_num2  <= '0;
            prob_op    <= '0;
            answer_q   <= '0;
            tries_left <= 4'(MAX_TRIES);
            solved     <= 1'b0;
            wrong      <= 1'b0;
        end else begin
            state_q <= state_d;
            solved  <= do_solve;
            wrong   <= do_wrong;
            if (do_latch) begin
                prob_num1  <= bus.gen_num1;
                prob_num2  <= bus.gen_num2;
                prob_op    <= bus.gen_op;
                answer_q   <= bus.gen_answer;
                tries_left <= 4'(MAX_TRIES);
            end else if (do_wrong) begin
                tries_left <= tries_left - 4'd1;
            end
        end
    end

`ifdef ANSWER_TIMEOUT_EN
    logic [15:0] timer_q;
    logic        timeout_q;

    assign timer_hit = (state_q == ST_ENTRY) && (timer_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    // Timer restarts only on a new problem; it pauses while judging
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= do_timeout;
            if (do_latch) begin
                timer_q <= '0;
            end else if (arm && state_q == ST_ENTRY && !timer_hit) begin
                timer_q <= timer_q + 16'd1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES) ^ do_timeout;
    assign timer_hit          = 1'b0;
    assign timeout            = 1'b0;
`endif

    digit_accumulator u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clear),
        .digit_valid (acc_digit),
        .digit       (bus.key_code),
        .entry       (entry),
        .entry_len   (entry_len)
    );

endmodule
